// File: rtl/seq_alu.sv
// Multicycle ALU with start/done handshake: single-cycle logic ops, shift-add multiply,
// and an optional restoring divider enabled by defining SEQ_ALU_DIV_EN.
module seq_alu #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] w_hi,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] w_q, w_d, w_hi_q, w_hi_d;
  logic             zero_q, zero_d, err_q, err_d;

  logic             start_long;
  logic [WIDTH-1:0] sc_w;
  logic             sc_err;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [WIDTH-1:0] step_hi, step_lo, fin_w, fin_hi;
  logic             fin_err;

  // {hi, lo} is the product register; lo starts as the multiplier and drains out the right
  assign mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
  logic [2:0]       op_q, op_d;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx, div_quo_nx;

  // hi holds the partial remainder, lo shifts the dividend out and the quotient in
  assign div_shift  = {hi_q, lo_q[WIDTH-1]};
  assign div_ge     = div_shift >= {1'b0, opnd_q};
  assign div_rem_nx = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
  assign div_quo_nx = {lo_q[WIDTH-2:0], div_ge};
  assign start_long = alu_op[2] & (alu_op[1] | alu_op[0]);

  always_comb begin
    step_hi = mul_hi_nx;
    step_lo = mul_lo_nx;
    fin_w   = mul_lo_nx;
    fin_hi  = mul_hi_nx;
    fin_err = 1'b0;
    if (op_q != 3'b101) begin
      step_hi = div_rem_nx;
      step_lo = div_quo_nx;
      fin_err = (opnd_q == '0);
      fin_w   = (op_q == 3'b110) ? div_quo_nx : div_rem_nx;
      fin_hi  = (op_q == 3'b110) ? div_rem_nx : div_quo_nx;
    end
  end
`else
  assign start_long = (alu_op == 3'b101);
  assign step_hi    = mul_hi_nx;
  assign step_lo    = mul_lo_nx;
  assign fin_w      = mul_lo_nx;
  assign fin_hi     = mul_hi_nx;
  assign fin_err    = 1'b0;
`endif

  // Without the divider, ops 110/111 fall to the default arm and flag err
  always_comb begin
    sc_w   = '0;
    sc_err = 1'b0;
    case (alu_op)
      3'b000:  sc_w = a + b;
      3'b001:  sc_w = a - b;
      3'b010:  sc_w = a & b;
      3'b011:  sc_w = ~b;
      3'b100:  sc_w = a;
      default: sc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    w_d     = w_q;
    w_hi_d  = w_hi_q;
    zero_d  = zero_q;
    err_d   = err_q;
`ifdef SEQ_ALU_DIV_EN
    op_d    = op_q;
`endif
    case (state_q)
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        hi_d  = step_hi;
        lo_d  = step_lo;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          w_d     = fin_w;
          w_hi_d  = fin_hi;
          zero_d  = (fin_w == '0);
          err_d   = fin_err;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          if (start_long) begin
            state_d = RUN;
            cnt_d   = CNT_W'(WIDTH);
            hi_d    = '0;
            opnd_d  = a;
            lo_d    = b;
`ifdef SEQ_ALU_DIV_EN
            op_d    = alu_op;
            if (alu_op != 3'b101) begin
              opnd_d = b;
              lo_d   = a;
            end
`endif
          end else begin
            state_d = DONE;
            w_d     = sc_w;
            w_hi_d  = '0;
            zero_d  = (sc_w == '0);
            err_d   = sc_err;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      w_q     <= '0;
      w_hi_q  <= '0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      op_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      w_q     <= w_d;
      w_hi_q  <= w_hi_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
`ifdef SEQ_ALU_DIV_EN
      op_q    <= op_d;
`endif
    end
  end

  assign w    = w_q;
  assign w_hi = w_hi_q;
  assign zero = zero_q;
  assign err  = err_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized ops against an arithmetic model.
module tb_seq_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   alu_op;
  logic [W-1:0] a, b, w, w_hi;
  logic         zero, busy, done, err;
  int           total = 0;
  int           bad = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .w(w), .w_hi(w_hi), .zero(zero), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
    end
  endtask

  // Reference results straight from the arithmetic meaning of each opcode
  task automatic modelOp(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] ew, output logic [W-1:0] eh, output logic ee,
                         output int lat);
    logic [2*W-1:0] prod;
    ew = '0; eh = '0; ee = 1'b0; lat = 1;
    case (op)
      3'd0: ew = x + y;
      3'd1: ew = x - y;
      3'd2: ew = x & y;
      3'd3: ew = ~y;
      3'd4: ew = x;
      3'd5: begin
        prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        ew = prod[W-1:0];
        eh = prod[2*W-1:W];
        lat = W + 1;
      end
      default: begin
`ifdef SEQ_ALU_DIV_EN
        logic [W-1:0] q, r;
        if (y == '0) begin
          q = '1; r = x; ee = 1'b1;
        end else begin
          q = x / y; r = x % y;
        end
        ew = (op == 3'd6) ? q : r;
        eh = (op == 3'd6) ? r : q;
        lat = W + 1;
`else
        ee = 1'b1;
`endif
      end
    endcase
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                               input bit pokeBusy);
    logic [W-1:0] ew, eh;
    logic         ee;
    int           elat, lat;
    modelOp(op, x, y, ew, eh, ee, elat);
    alu_op = op; a = x; b = y; start = 1'b1;
    tick;
    start = 1'b0;
    alu_op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!done && lat < 4 * W) begin
      checkOutput("busy_run", busy, 1);
      if (pokeBusy) begin
        start = 1'($urandom);
        alu_op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      end
      tick;
      start = 1'b0;
      lat++;
    end
    checkOutput("latency", lat, elat);
    checkOutput("done", done, 1);
    checkOutput("w", w, ew);
    checkOutput("w_hi", w_hi, eh);
    checkOutput("zero", zero, (ew == '0));
    checkOutput("err", err, ee);
    checkOutput("busy_done", busy, 0);
    tick;
    checkOutput("done_once", done, 0);
    checkOutput("w_hold", w, ew);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_w"}, w, 0);
    checkOutput({tag, "_w_hi"}, w_hi, 0);
    checkOutput({tag, "_zero"}, zero, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bit sawDone;
    rst = 1'b1; start = 1'b0; alu_op = '0; a = '0; b = '0;
    tick; tick;
    checkResetState("reset");
    rst = 1'b0;
    tick;

    applyStimulus(3'd0, 16'h0000, 16'hFFFF, 1'b0);
    applyStimulus(3'd1, 16'h0000, 16'hFFFF, 1'b0);
    applyStimulus(3'd3, 16'h1234, 16'hFFFF, 1'b0);
    applyStimulus(3'd4, 16'h0000, 16'h5555, 1'b0);
    applyStimulus(3'd4, 16'h0005, 16'h0000, 1'b0);
    applyStimulus(3'd5, 16'hFFFF, 16'hFFFF, 1'b1);
    applyStimulus(3'd6, 16'd100, 16'd7, 1'b1);
    applyStimulus(3'd7, 16'd100, 16'd7, 1'b0);
    applyStimulus(3'd6, 16'd100, 16'd0, 1'b0);
    applyStimulus(3'd7, 16'd100, 16'd0, 1'b0);

    // Back-to-back single-cycle ops: start held through the DONE cycle
    alu_op = 3'd0; a = 16'd1; b = 16'd2; start = 1'b1;
    tick;
    checkOutput("b2b_done1", done, 1);
    checkOutput("b2b_w1", w, 16'd3);
    alu_op = 3'd1; a = 16'd5; b = 16'd3;
    tick;
    checkOutput("b2b_done2", done, 1);
    checkOutput("b2b_w2", w, 16'd2);
    start = 1'b0;
    tick;
    checkOutput("b2b_idle", done, 0);

    // Reset in the middle of a multiply aborts it without a done pulse
    applyStimulus(3'd0, 16'h1234, 16'h1111, 1'b0);
    alu_op = 3'd5; a = 16'h00F3; b = 16'h0003; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkResetState("abort");
    sawDone = 1'b0;
    repeat (W + 4) begin
      tick;
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort_nodone", sawDone, 0);
    applyStimulus(3'd0, 16'h0F0F, 16'h0101, 1'b0);

    // Reset takes priority over a simultaneous start
    rst = 1'b1; start = 1'b1; alu_op = 3'd0; a = 16'd5; b = 16'd5;
    tick;
    rst = 1'b0; start = 1'b0;
    checkOutput("rst_wins_done", done, 0);
    checkOutput("rst_wins_w", w, 0);
    tick;
    checkOutput("rst_wins_after", done, 0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
